// File: rtl/light_monitor.sv
// light_monitor: passive safety checker for a two-road traffic-light output bus.
// Define LIGHT_MONITOR_STAT_EN to add per-road completed-green-phase counters.
module light_monitor #(
  parameter int CW         = 8,
  parameter int YELLOW_LEN = 3,
  parameter int MIN_GREEN  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_light_a,
  input  logic [1:0]  i_light_b,
  input  logic        i_clr,
  output logic        o_err_pulse,
  output logic        o_err_sticky,
  output logic [2:0]  o_err_code,
  output logic        o_err_road,
  output logic [1:0]  o_phase_a,
  output logic [1:0]  o_phase_b
`ifdef LIGHT_MONITOR_STAT_EN
  ,
  output logic [15:0] o_green_cnt_a,
  output logic [15:0] o_green_cnt_b
`endif
);

  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_RED    = 2'b10;
  localparam logic [1:0] PH_BAD    = 2'b11;

  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] YEL_CNT     = CW'(YELLOW_LEN);
  localparam logic [CW-1:0] MIN_GRN_CNT = CW'(MIN_GREEN);

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ILLEGAL  = 3'd1;
  localparam logic [2:0] E_CONFLICT = 3'd2;
  localparam logic [2:0] E_TRANS    = 3'd3;
  localparam logic [2:0] E_YELLOW   = 3'd4;
  localparam logic [2:0] E_GREEN    = 3'd5;

  typedef struct packed {
    logic          ill;
    logic          trans;
    logic          yel;
    logic          grn;
    logic [CW-1:0] cnt;
  } road_chk_t;

  // Per-road checks of the current sample against the previous one; cnt is the
  // next value of that road's duration counter.
  function automatic road_chk_t eval_road(input logic [1:0]    cur,
                                          input logic [1:0]    prev,
                                          input logic [CW-1:0] cnt,
                                          input logic          primed);
    road_chk_t res;
    logic      changed;
    changed   = (cur != prev);
    res.ill   = (cur == PH_BAD);
    res.trans = primed && ((prev == PH_GREEN  && cur == PH_RED)    ||
                           (prev == PH_YELLOW && cur == PH_GREEN)  ||
                           (prev == PH_RED    && cur == PH_YELLOW));
    res.yel   = primed && changed && (prev == PH_YELLOW) && (cnt != YEL_CNT);
    res.grn   = primed && changed && (prev == PH_GREEN) && (cnt < MIN_GRN_CNT);
    if (!primed || changed) begin
      res.cnt = CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      res.cnt = cnt + CNT_ONE;
    end else begin
      res.cnt = cnt;
    end
    return res;
  endfunction

  logic [1:0]    phase_a_q, phase_b_q;
  logic [CW-1:0] cnt_a_q, cnt_b_q;
  logic          primed_q;
  logic          pulse_q;
  logic          sticky_q, sticky_d;
  logic [2:0]    code_q, code_d;
  logic          road_q, road_d;

  road_chk_t     chk_a, chk_b;
  logic          conflict_err;
  logic          any_err;
  logic [2:0]    first_code;
  logic          first_road;

  always_comb begin
    chk_a = eval_road(i_light_a, phase_a_q, cnt_a_q, primed_q);
    chk_b = eval_road(i_light_b, phase_b_q, cnt_b_q, primed_q);
  end

  // 11 counts as non-RED here, so an invalid code beside a lit road also conflicts.
  assign conflict_err = (i_light_a != PH_RED) && (i_light_b != PH_RED);

  // Lowest code wins, road A before road B within one code.
  always_comb begin
    first_code = E_NONE;
    first_road = 1'b0;
    if (chk_a.ill) begin
      first_code = E_ILLEGAL;
    end else if (chk_b.ill) begin
      first_code = E_ILLEGAL;
      first_road = 1'b1;
    end else if (conflict_err) begin
      first_code = E_CONFLICT;
    end else if (chk_a.trans) begin
      first_code = E_TRANS;
    end else if (chk_b.trans) begin
      first_code = E_TRANS;
      first_road = 1'b1;
    end else if (chk_a.yel) begin
      first_code = E_YELLOW;
    end else if (chk_b.yel) begin
      first_code = E_YELLOW;
      first_road = 1'b1;
    end else if (chk_a.grn) begin
      first_code = E_GREEN;
    end else if (chk_b.grn) begin
      first_code = E_GREEN;
      first_road = 1'b1;
    end
  end

  assign any_err = (first_code != E_NONE);

  // A clear in the same cycle as a new violation still captures the violation.
  always_comb begin
    sticky_d = sticky_q;
    code_d   = code_q;
    road_d   = road_q;
    if (i_clr) begin
      sticky_d = 1'b0;
      code_d   = E_NONE;
      road_d   = 1'b0;
    end
    if (any_err && (!sticky_q || i_clr)) begin
      sticky_d = 1'b1;
      code_d   = first_code;
      road_d   = first_road;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_a_q <= PH_RED;
      phase_b_q <= PH_RED;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      primed_q  <= 1'b0;
      pulse_q   <= 1'b0;
      sticky_q  <= 1'b0;
      code_q    <= E_NONE;
      road_q    <= 1'b0;
    end else begin
      phase_a_q <= i_light_a;
      phase_b_q <= i_light_b;
      cnt_a_q   <= chk_a.cnt;
      cnt_b_q   <= chk_b.cnt;
      primed_q  <= 1'b1;
      pulse_q   <= any_err;
      sticky_q  <= sticky_d;
      code_q    <= code_d;
      road_q    <= road_d;
    end
  end

  assign o_err_pulse  = pulse_q;
  assign o_err_sticky = sticky_q;
  assign o_err_code   = code_q;
  assign o_err_road   = road_q;
  assign o_phase_a    = phase_a_q;
  assign o_phase_b    = phase_b_q;

`ifdef LIGHT_MONITOR_STAT_EN
  logic [15:0] green_a_q, green_a_d;
  logic [15:0] green_b_q, green_b_d;
  logic        green_exit_a, green_exit_b;

  assign green_exit_a = (phase_a_q == PH_GREEN) && (i_light_a != PH_GREEN);
  assign green_exit_b = (phase_b_q == PH_GREEN) && (i_light_b != PH_GREEN);

  always_comb begin
    green_a_d = green_a_q;
    green_b_d = green_b_q;
    if (i_clr) begin
      green_a_d = '0;
      green_b_d = '0;
    end else begin
      if (green_exit_a && green_a_q != 16'hFFFF) green_a_d = green_a_q + 16'd1;
      if (green_exit_b && green_b_q != 16'hFFFF) green_b_d = green_b_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      green_a_q <= '0;
      green_b_q <= '0;
    end else begin
      green_a_q <= green_a_d;
      green_b_q <= green_b_d;
    end
  end

  assign o_green_cnt_a = green_a_q;
  assign o_green_cnt_b = green_b_q;
`endif

endmodule
